muxn_rr: RTL and testbench
==========================

Name: muxn_rr

Overview:
- Parametrised successor to the team's 2:1 mux: N input channels, W bits each, with valid/ready handshakes.
- Selects one channel per transfer using round-robin arbitration.
- Output is registered and reports which channel each word came from.
- Sits between multiple producer blocks and a single shared consumer, such as a shared display or bus interface.

Parameters:
- N, default 4, number of input channels; legal range 2..16.
- W, default 8, data width per channel in bits; legal range 1 or more.
- CH_W, default $clog2(N), width of the channel index; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  N*W  flattened channel data; channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; at most one bit is high in any cycle.
- out_data  out  W  registered selected data.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word.
- out_ch  out  CH_W  source channel of out_data.

Behaviour:
- Reset is asynchronous, active-low, on rst_n. While rst_n=0:
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=0.
  - in_ready=0.
- Load condition: load = !out_valid || out_ready. This allows full throughput of one word per cycle.
- Arbitration is combinational:
  - grant = the first i with in_valid[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
  - in_ready[grant] = load; all other in_ready bits are 0.
  - With no requesters, in_ready = 0.
- Transfer: on a clock edge where load=1 and a grant exists:
  - out_data <= channel data, out_ch <= grant, out_valid <= 1.
  - ptr <= (grant+1) mod N. The wrap from N-1 to 0 is explicit and works for non-power-of-2 N.
- Load with no requester: if load=1 and no channel is valid, out_valid <= 0. out_data and out_ch hold their last values.
- Backpressure: if out_valid=1 and out_ready=0:
  - All output registers hold.
  - in_ready = 0.
  - ptr holds.
- Latency: a word accepted in cycle t appears on out_data in cycle t+1.
- Fairness: every continuously-valid channel is served within N transfers.
- Ready/valid dependency: in_valid may depend on in_ready only as permitted by the handshake. in_ready depends combinationally on in_valid and out_ready; there is no combinational path from in_data.
- Simultaneous events: out_ready=1 together with a new request replaces the word in the same cycle, with no bubble.
- Reset mid-transfer: the registered word is discarded and ptr returns to 0.

Optional Feature:
- Macro MUXN_RR_PKT_LOCK_EN.
- Defined:
  - Adds ports in_last (in, N) and out_last (out, 1, reset 0).
  - After a grant whose in_last bit is 0, arbitration locks to that channel. Other channels get no in_ready until the locked channel transfers a word with in_last=1.
  - ptr advances only on that last word.
  - out_last is registered alongside out_data.
- Undefined: no extra ports, and every word is arbitrated independently.

Decomposition:
- Package muxn_pkg holds:
  - the default N and W constants;
  - function rr_pick(valid, ptr), which returns the granted index and a found bit.
- One sub-module, rr_arbiter, which is natural to separate:
  - inputs: valid, ptr, enable;
  - outputs: one-hot grant and the encoded index;
  - purely combinational.
- muxn_rr owns the output registers, ptr and the lock logic.

Test Plan:
- Reset: hold rst_n=0 with in_valid=4'b1111 -> out_valid=0, out_data=0, out_ch=0, in_ready=0; release rst_n -> first transfer comes from channel 0.
- Round robin: N=4, W=8, all valid, data ch0..3 = 8'h10, 8'h21, 8'h32, 8'h43, out_ready=1 -> out_ch sequence 0,1,2,3,0, one word per cycle, data matches.
- Sparse requests: only ch1 and ch3 valid, ptr=2 -> ch3 granted first, then ch1, then ch3.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data is stable, in_ready=0, ptr is unchanged; on out_ready=1 the next channel transfers in the same cycle.
- Non-power-of-2 wrap: N=3, all valid -> out_ch sequence 0,1,2,0; out_ch never equals 3.
- Mid-operation reset and lock (with MUXN_RR_PKT_LOCK_EN): ch2 sends a 3-word packet, last flag on word 3, while ch0 is valid -> ch0 is blocked until out_last=1, then ch0 is granted. Assert rst_n=0 during word 2 -> out_valid=0 immediately and the lock is cleared.

Source files
------------

// File: rtl/muxn_pkg.sv
// rtl/muxn_pkg.sv - shared constants, types and the round-robin pick function for muxn_rr
package muxn_pkg;

    localparam int MUXN_DEF_N = 4;
    localparam int MUXN_DEF_W = 8;
    localparam int MUXN_MAX_N = 16;
    localparam int RR_IDX_W   = 4;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First valid index scanning ptr, ptr+1, ..., n-1, 0, ..., ptr-1.
    // Inputs are padded to the maximum channel count; n is the live count.
    function automatic rr_pick_t rr_pick(
        input logic [MUXN_MAX_N-1:0] valid,
        input logic [RR_IDX_W-1:0]   ptr,
        input int                    n
    );
        rr_pick_t r;
        int       k;
        r = '0;
        for (int off = 0; off < MUXN_MAX_N; off++) begin
            if (off < n && !r.found) begin
                k = int'(ptr) + off;
                if (k >= n) begin
                    k = k - n;
                end
                if (valid[k]) begin
                    r.found = 1'b1;
                    r.idx   = RR_IDX_W'(k);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter with one-hot grant and encoded index
module rr_arbiter
    import muxn_pkg::*;
#(
    parameter  int N    = MUXN_DEF_N,
    localparam int CH_W = $clog2(N)
) (
    input  logic [N-1:0]    valid,
    input  logic [CH_W-1:0] ptr,
    input  logic            enable,
    output logic [N-1:0]    grant,
    output logic [CH_W-1:0] idx,
    output logic            found
);

    rr_pick_t pick;
    logic     unused_idx_bits;

    // Pick the winner; the one-hot grant is only raised when the consumer side can load.
    always_comb begin
        pick  = rr_pick(MUXN_MAX_N'(valid), RR_IDX_W'(ptr), N);
        found = pick.found;
        idx   = CH_W'(pick.idx);
        grant = '0;
        if (enable && pick.found) begin
            grant[idx] = 1'b1;
        end
    end

    // Upper index bits are always zero for small N; fold them away explicitly.
    assign unused_idx_bits = ^pick.idx;

endmodule

// File: rtl/muxn_rr.sv
// rtl/muxn_rr.sv - N-channel round-robin mux with registered output; optional packet lock via MUXN_RR_PKT_LOCK_EN
module muxn_rr
    import muxn_pkg::*;
#(
    parameter  int N    = MUXN_DEF_N,
    parameter  int W    = MUXN_DEF_W,
    localparam int CH_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
`ifdef MUXN_RR_PKT_LOCK_EN
    input  logic [N-1:0]    in_last,
    output logic            out_last,
`endif
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH_W-1:0] out_ch
);

    logic            load;
    logic            found;
    logic            xfer;
    logic [N-1:0]    arb_valid;
    logic [N-1:0]    grant;
    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] arb_ptr;
    logic [CH_W-1:0] idx;
    logic [CH_W-1:0] ptr_next;

    // The output slot can take a word when empty or being drained this cycle.
    assign load = !out_valid || out_ready;

`ifdef MUXN_RR_PKT_LOCK_EN
    logic            locked;
    logic [CH_W-1:0] lock_ch;

    // While a packet is open only its channel may compete.
    always_comb begin
        arb_valid = in_valid;
        arb_ptr   = ptr;
        if (locked) begin
            arb_valid          = '0;
            arb_valid[lock_ch] = in_valid[lock_ch];
            arb_ptr            = lock_ch;
        end
    end
`else
    assign arb_valid = in_valid;
    assign arb_ptr   = ptr;
`endif

    rr_arbiter #(.N(N)) u_arb (
        .valid  (arb_valid),
        .ptr    (arb_ptr),
        .enable (load && rst_n),
        .grant  (grant),
        .idx    (idx),
        .found  (found)
    );

    assign in_ready = grant;
    assign xfer     = load && found;
    assign ptr_next = (idx == CH_W'(N - 1)) ? '0 : idx + 1'b1;

    // Output word register: capture the granted word, or drop to empty when nobody requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
`ifdef MUXN_RR_PKT_LOCK_EN
            out_last  <= 1'b0;
`endif
        end else if (load) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(idx)*W +: W];
                out_ch    <= idx;
`ifdef MUXN_RR_PKT_LOCK_EN
                out_last  <= in_last[idx];
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Round-robin pointer (and packet lock) advance only on an actual transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
`ifdef MUXN_RR_PKT_LOCK_EN
            locked  <= 1'b0;
            lock_ch <= '0;
`endif
        end else if (xfer) begin
`ifdef MUXN_RR_PKT_LOCK_EN
            if (in_last[idx]) begin
                ptr    <= ptr_next;
                locked <= 1'b0;
            end else begin
                locked  <= 1'b1;
                lock_ch <= idx;
            end
`else
            ptr <= ptr_next;
`endif
        end
    end

endmodule

// File: tb/tb_muxn_rr.sv
// tb/tb_muxn_rr.sv - directed self-checking bench for muxn_rr (N=4 and N=3 instances)
module tb_muxn_rr;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  in_last;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
    logic        out_last;

    logic [23:0] d3_data;
    logic [2:0]  d3_valid;
    logic [2:0]  d3_in_ready;
    logic [2:0]  d3_last;
    logic [7:0]  d3_out_data;
    logic        d3_out_valid;
    logic        d3_out_ready;
    logic [1:0]  d3_out_ch;
    logic        d3_out_last;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_ch4 [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] exp_d4  [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    logic [1:0] exp_ch3 [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [7:0] exp_d3  [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hA0};

    always #5 clk = ~clk;

    muxn_rr #(.N(4), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef MUXN_RR_PKT_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
    );

    muxn_rr #(.N(3), .W(8)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (d3_data),
        .in_valid  (d3_valid),
        .in_ready  (d3_in_ready),
`ifdef MUXN_RR_PKT_LOCK_EN
        .in_last   (d3_last),
        .out_last  (d3_out_last),
`endif
        .out_data  (d3_out_data),
        .out_valid (d3_out_valid),
        .out_ready (d3_out_ready),
        .out_ch    (d3_out_ch)
    );

`ifndef MUXN_RR_PKT_LOCK_EN
    assign out_last    = 1'b0;
    assign d3_out_last = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        in_valid     = 4'hF;
        in_data      = {8'h43, 8'h32, 8'h21, 8'h10};
        in_last      = 4'hF;
        out_ready    = 1'b1;
        d3_valid     = 3'b000;
        d3_data      = {8'hC2, 8'hB1, 8'hA0};
        d3_last      = 3'b111;
        d3_out_ready = 1'b1;

        // Reset state with all channels requesting
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_ch",    32'(out_ch),    32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);

        // Release: channel 0 is offered first
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'h1);

        // Round robin, all valid, full throughput
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_valid", 32'(out_valid), 32'd1);
            check("rr_ch",    32'(out_ch),    32'(exp_ch4[i]));
            check("rr_data",  32'(out_data),  32'(exp_d4[i]));
        end

        // Backpressure: hold for three edges with ch0 word parked
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_data",     32'(out_data), 32'h10);
            check("bp_ch",       32'(out_ch),   32'd0);
            check("bp_valid",    32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'h2);
        tick();
        check("bp_next_ch",   32'(out_ch),   32'd1);
        check("bp_next_data", 32'(out_data), 32'h21);

        // Sparse: ch1 and ch3 valid with ptr at 2
        in_valid = 4'b1010;
        #1;
        check("sp_ready0", 32'(in_ready), 32'h8);
        tick();
        check("sp_ch0",   32'(out_ch),   32'd3);
        check("sp_data0", 32'(out_data), 32'h43);
        check("sp_ready1", 32'(in_ready), 32'h2);
        tick();
        check("sp_ch1", 32'(out_ch), 32'd1);
        tick();
        check("sp_ch2", 32'(out_ch), 32'd3);

        // No requesters: output empties, data and channel hold
        in_valid = 4'b0000;
        tick();
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_data",  32'(out_data),  32'h43);
        check("idle_ch",    32'(out_ch),    32'd3);
        check("idle_ready", 32'(in_ready),  32'd0);

        // New data pattern, then reset mid-stream
        in_data  = {8'hFF, 8'h00, 8'hA5, 8'h5A};
        in_valid = 4'hF;
        tick();
        check("pat_ch0",   32'(out_ch),   32'd0);
        check("pat_data0", 32'(out_data), 32'h5A);
        tick();
        check("pat_ch1",   32'(out_ch),   32'd1);
        check("pat_data1", 32'(out_data), 32'hA5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data",  32'(out_data),  32'd0);
        check("mid_rst_ready", 32'(in_ready),  32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready", 32'(in_ready), 32'h1);
        tick();
        check("mid_rel_ch",   32'(out_ch),   32'd0);
        check("mid_rel_data", 32'(out_data), 32'h5A);

        // Non-power-of-2 wrap on the N=3 instance
        in_valid = 4'b0000;
        d3_valid = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("n3_valid", 32'(d3_out_valid), 32'd1);
            check("n3_ch",    32'(d3_out_ch),    32'(exp_ch3[i]));
            check("n3_data",  32'(d3_out_data),  32'(exp_d3[i]));
        end
        d3_valid = 3'b000;

`ifdef MUXN_RR_PKT_LOCK_EN
        // Packet lock: ch2 sends three words while ch0 waits
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        in_data  = {8'h44, 8'hA1, 8'h22, 8'h0F};
        in_last  = 4'b0000;
        in_valid = 4'b0100;
        #1;
        check("lk_ready_w1", 32'(in_ready), 32'h4);
        tick();
        check("lk_ch_w1",   32'(out_ch),   32'd2);
        check("lk_data_w1", 32'(out_data), 32'hA1);
        check("lk_last_w1", 32'(out_last), 32'd0);
        in_data[16 +: 8] = 8'hA2;
        in_valid = 4'b0101;
        #1;
        check("lk_ready_w2", 32'(in_ready), 32'h4);
        tick();
        check("lk_data_w2", 32'(out_data), 32'hA2);
        check("lk_last_w2", 32'(out_last), 32'd0);
        in_data[16 +: 8] = 8'hA3;
        in_last  = 4'b0101;
        #1;
        check("lk_ready_w3", 32'(in_ready), 32'h4);
        tick();
        check("lk_data_w3", 32'(out_data), 32'hA3);
        check("lk_last_w3", 32'(out_last), 32'd1);
        in_valid = 4'b0001;
        #1;
        check("lk_ready_ch0", 32'(in_ready), 32'h1);
        tick();
        check("lk_ch0",   32'(out_ch),   32'd0);
        check("lk_data0", 32'(out_data), 32'h0F);

        // Reset in the middle of a packet clears the lock
        in_data[16 +: 8] = 8'hA1;
        in_last  = 4'b0000;
        in_valid = 4'b0100;
        tick();
        check("lk2_ch_w1", 32'(out_ch), 32'd2);
        in_valid = 4'b0101;
        #1;
        check("lk2_ready_w2", 32'(in_ready), 32'h4);
        rst_n = 1'b0;
        #1;
        check("lk2_rst_valid", 32'(out_valid), 32'd0);
        check("lk2_rst_last",  32'(out_last),  32'd0);
        check("lk2_rst_ready", 32'(in_ready),  32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("lk2_unlocked_ready", 32'(in_ready), 32'h1);
        tick();
        check("lk2_unlocked_ch", 32'(out_ch), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
